// File: rtl/idli_sqi_ctrl.sv
// SQI transaction sequencer for the lockstepped LO/HI memories: cmd, addr, dummy, data, deselect.
// Optional IDLI_SQI_RD_PIPE_EN adds a second read capture stage and a 2-cycle DESEL.
module idli_sqi_ctrl #(
    parameter int ADDR_W       = 16,
    parameter int DUMMY_CYCLES = 2,
    localparam int SQI_NUM     = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_vld,
    output logic                 o_req_rdy,
    input  logic [ADDR_W-1:0]    i_req_addr,
    input  logic                 i_req_wr,
    input  logic                 i_end,
    input  logic [7:0]           i_wr_data,
    output logic                 o_wr_rdy,
    output logic                 o_rd_vld,
    output logic [SQI_NUM*4-1:0] o_rd_data,
    output logic                 o_sqi_cs_n,
    output logic                 o_sqi_sck_en,
    output logic                 o_sqi_oe,
    output logic [SQI_NUM*4-1:0] o_sqi_sio,
    input  logic [SQI_NUM*4-1:0] i_sqi_sio
);

    typedef enum logic {
        SQI_MEM_LO = 1'b0,
        SQI_MEM_HI = 1'b1
    } sqi_mem_t;

    localparam int NIB_N = ADDR_W / 4;
    localparam int CNT_W = 8;
`ifdef IDLI_SQI_RD_PIPE_EN
    localparam int DESEL_N = 2;
`else
    localparam int DESEL_N = 1;
`endif
    localparam int HI_B = int'(SQI_MEM_HI) * 4;
    localparam int LO_B = int'(SQI_MEM_LO) * 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_DESEL
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 wr_q, wr_d;
    logic [3:0]           nib;
    logic [SQI_NUM*4-1:0] sio;
    logic                 rd_cap;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        addr_d     = addr_q;
        wr_d       = wr_q;
        o_req_rdy  = 1'b0;
        o_sqi_cs_n = 1'b0;
        o_sqi_oe   = 1'b0;
        o_wr_rdy   = 1'b0;
        rd_cap     = 1'b0;
        nib        = 4'h0;
        sio        = '0;
        unique case (state_q)
            ST_IDLE: begin
                o_req_rdy  = 1'b1;
                o_sqi_cs_n = 1'b1;
                cnt_d      = '0;
                if (i_req_vld) begin
                    state_d = ST_CMD;
                    addr_d  = i_req_addr;
                    wr_d    = i_req_wr;
                end
            end
            ST_CMD: begin
                // 0x02 write / 0x03 read: high nibble 0, then {001, rd}
                o_sqi_oe = 1'b1;
                nib      = cnt_q[0] ? {3'b001, !wr_q} : 4'h0;
                sio      = {SQI_NUM{nib}};
                if (cnt_q[0]) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                end
            end
            ST_ADDR: begin
                o_sqi_oe = 1'b1;
                nib      = addr_q[ADDR_W-1 -: 4];
                sio      = {SQI_NUM{nib}};
                addr_d   = addr_q << 4;
                if (cnt_q == CNT_W'(NIB_N - 1)) begin
                    state_d = wr_q ? ST_DATA : ST_DUMMY;
                    cnt_d   = '0;
                end
            end
            ST_DUMMY: begin
                if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                o_sqi_oe = wr_q;
                o_wr_rdy = wr_q;
                rd_cap   = !wr_q;
                if (wr_q) begin
                    sio[HI_B +: 4] = i_wr_data[7:4];
                    sio[LO_B +: 4] = i_wr_data[3:0];
                end
                if (i_end) begin
                    state_d = ST_DESEL;
                    cnt_d   = '0;
                end
            end
            ST_DESEL: begin
                o_sqi_cs_n = 1'b1;
                if (cnt_q == CNT_W'(DESEL_N - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_sqi_sck_en = !o_sqi_cs_n;
    assign o_sqi_sio    = sio;

    logic                 rd_vld_q;
    logic [SQI_NUM*4-1:0] rd_data_q;

`ifdef IDLI_SQI_RD_PIPE_EN
    logic                 rd_vld_p_q;
    logic [SQI_NUM*4-1:0] rd_data_p_q;

    // Pad-side register runs free; the valid flag travels alongside it
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_vld_p_q  <= 1'b0;
            rd_data_p_q <= '0;
            rd_vld_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            rd_vld_p_q  <= rd_cap;
            rd_data_p_q <= i_sqi_sio;
            rd_vld_q    <= rd_vld_p_q;
            if (rd_vld_p_q) begin
                rd_data_q <= rd_data_p_q;
            end
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q <= rd_cap;
            if (rd_cap) begin
                rd_data_q <= i_sqi_sio;
            end
        end
    end
`endif

    assign o_rd_vld  = rd_vld_q;
    assign o_rd_data = rd_data_q;

endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// Randomized bench for idli_sqi_ctrl against a per-transaction cycle-trace model.
// Honours IDLI_SQI_RD_PIPE_EN for read latency and DESEL length.
module tb_idli_sqi_ctrl;

    localparam int AW = 16;
    localparam int NA = AW / 4;
    localparam int DC = 2;
`ifdef IDLI_SQI_RD_PIPE_EN
    localparam int LAT = 2;
    localparam int DSL = 2;
`else
    localparam int LAT = 1;
    localparam int DSL = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic [AW-1:0] req_addr = '0;
    logic          req_wr = 1'b0;
    logic          end_i = 1'b0;
    logic [7:0]    wr_data = '0;
    logic          wr_rdy;
    logic          rd_vld;
    logic [7:0]    rd_data;
    logic          cs_n;
    logic          sck_en;
    logic          oe;
    logic [7:0]    sio_o;
    logic [7:0]    sio_i = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    idli_sqi_ctrl #(
        .ADDR_W(AW),
        .DUMMY_CYCLES(DC)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_req_vld(req_vld),
        .o_req_rdy(req_rdy),
        .i_req_addr(req_addr),
        .i_req_wr(req_wr),
        .i_end(end_i),
        .i_wr_data(wr_data),
        .o_wr_rdy(wr_rdy),
        .o_rd_vld(rd_vld),
        .o_rd_data(rd_data),
        .o_sqi_cs_n(cs_n),
        .o_sqi_sck_en(sck_en),
        .o_sqi_oe(oe),
        .o_sqi_sio(sio_o),
        .i_sqi_sio(sio_i)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {cs_n, sck_en, oe, wr_rdy, req_rdy, rd_vld, rd_data, sio}
    function automatic logic [31:0] pk(logic cs, logic sck, logic o,
                                       logic wrr, logic rq, logic vld,
                                       logic [7:0] rdd, logic [7:0] s);
        return {10'd0, cs, sck, o, wrr, rq, vld, (vld ? rdd : 8'h00), s};
    endfunction

    function automatic logic [31:0] obs();
        return pk(cs_n, sck_en, oe, wr_rdy, req_rdy, rd_vld, rd_data, sio_o);
    endfunction

    function automatic logic [31:0] idle_vec();
        return pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    endfunction

    task automatic rand_inputs();
        req_addr = AW'($urandom);
        req_wr   = 1'($urandom);
        end_i    = 1'($urandom);
        wr_data  = 8'($urandom);
        sio_i    = 8'($urandom);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rand_inputs();
            req_vld = 1'b0;
            #1;
            chk(tag, obs(), idle_vec());
        end
    endtask

    // Full transaction from the accept cycle (c=0) to the last DESEL cycle
    task automatic run_txn(input logic [AW-1:0] addr, input bit wr,
                           input int k, input bit fixed,
                           input logic [31:0] fd, input bit endhold);
        int s;
        int n;
        int di;
        int ri;
        bit dat;
        logic [7:0] cmd;
        logic [7:0] b;
        logic [7:0] es;
        logic [7:0] erd;
        logic [3:0] nb;
        bit ecs, eoe, ewr, ervld;
        logic [7:0] cap[$];
        s   = 3 + NA + (wr ? 0 : DC);
        n   = s + k + DSL;
        cmd = wr ? 8'h02 : 8'h03;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            dat = (c >= s) && (c < s + k);
            di  = c - s;
            rand_inputs();
            b = 8'($urandom);
            if (fixed && dat) b = 8'(fd >> (8 * di));
            wr_data = b;
            sio_i   = b;
            req_vld = (c == 0) ? 1'b1 : 1'($urandom);
            if (c == 0) begin
                req_addr = addr;
                req_wr   = wr;
            end
            if (dat) end_i = (di == k - 1);
            else if (endhold) end_i = 1'b1;
            if (dat && !wr) cap.push_back(b);
            ecs = (c == 0) || (c >= s + k);
            eoe = (c >= 1 && c < 3 + NA) || (dat && wr);
            ewr = dat && wr;
            es  = 8'h00;
            if (c >= 1 && c <= 2) begin
                nb = 4'(cmd >> (4 * (2 - c)));
                es = {nb, nb};
            end else if (c >= 3 && c < 3 + NA) begin
                nb = 4'(addr >> (4 * (NA - 1 - (c - 3))));
                es = {nb, nb};
            end else if (ewr) begin
                es = b;
            end
            ri    = c - LAT - s;
            ervld = !wr && (ri >= 0) && (ri < k);
            erd   = ervld ? cap[ri] : 8'h00;
            #1;
            chk($sformatf("%s@%h c%0d", wr ? "wr" : "rd", addr, c), obs(),
                pk(ecs, !ecs, eoe, ewr, (c == 0), ervld, erd, es));
        end
        req_vld = 1'b0;
    endtask

    // Start a read and pull reset during cycle 'at'; nothing may leak out
    task automatic abort_rd(input int at);
        for (int c = 0; c <= at; c++) begin
            @(negedge clk);
            rand_inputs();
            end_i   = 1'b0;
            req_vld = (c == 0);
            req_wr  = 1'b0;
            if (c == at) begin
                #1;
                chk($sformatf("pre_rst c%0d cs", at), 32'(cs_n), 32'd0);
                rst_n = 1'b0;
            end
        end
        @(negedge clk);
        req_vld = 1'b0;
        rst_n   = 1'b1;
        #1;
        chk($sformatf("post_rst c%0d", at), obs(), idle_vec());
        idle(3, "rst_drain");
    endtask

    initial begin
        int gap;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset", obs(), idle_vec());
        rst_n = 1'b1;
        idle(2, "idle");

        run_txn(16'h1234, 1'b0, 2, 1'b1, 32'h5A5A5A5A, 1'b0);
        idle(1, "gap");
        run_txn(16'hBEEF, 1'b1, 2, 1'b1, 32'h00003412, 1'b0);
        idle(1, "gap");
        run_txn(16'hA5C3, 1'b0, 3, 1'b0, 32'h0, 1'b0);
        run_txn(16'h0F0F, 1'b1, 1, 1'b0, 32'h0, 1'b0);
        run_txn(16'hFFFF, 1'b0, 1, 1'b0, 32'h0, 1'b0);
        idle(1, "gap");
        run_txn(16'h4321, 1'b0, 1, 1'b0, 32'h0, 1'b1);
        run_txn(16'h8001, 1'b1, 1, 1'b0, 32'h0, 1'b1);
        idle(1, "gap");

        abort_rd(4);
        run_txn(16'h1234, 1'b0, 2, 1'b0, 32'h0, 1'b0);
        abort_rd(3 + NA + DC);
        run_txn(16'h5678, 1'b0, 2, 1'b0, 32'h0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(gap, "rgap");
            run_txn(AW'($urandom), 1'($urandom), $urandom_range(1, 4),
                    1'b0, 32'h0, 1'($urandom));
        end
        idle(2, "tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
